ni_injector: RTL and testbench

Network-interface injector for a router's local input port. It accepts packet descriptors and payload words from a processing element, segments each packet into flits, and drives the router's local `data_in`/`is_valid_in` pins. Flits leave only when the router's `is_allocatable` and `is_on_off` feedback for that port permit it. This is the upstream counterpart of the router's input block: it produces exactly the flit stream that the input block buffers.

---
 rtl/noc_params.sv | 33 +++
 rtl/ni_flit_reg.sv | 31 +++
 rtl/ni_injector.sv | 124 ++++++++++++
 tb/tb_ni_injector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC parameters, flit layout and head-flit packing used by routers
// and network interfaces.
package noc_params;

  localparam int VC_NUM           = 2;
  localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int FLIT_DATA_SIZE   = 16;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int HEAD_PAD_W       = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t                flit_label;
    logic [VC_SIZE-1:0]         vc_id;
    logic [FLIT_DATA_SIZE-1:0]  data;
  } flit_t;

  // Destination sits in the top bits so routing can slice it without knowing the pad.
  function automatic logic [FLIT_DATA_SIZE-1:0] pack_head(
    input logic [DEST_ADDR_SIZE_X-1:0] x,
    input logic [DEST_ADDR_SIZE_Y-1:0] y
  );
    return {x, y, {HEAD_PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ni_flit_reg.sv
// Output register for the injector's flit pins; data holds between flits.
module ni_flit_reg
  import noc_params::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_valid,
  input  flit_t i_flit,
  output logic  o_valid,
  output flit_t o_flit
);

  logic  r_valid;
  flit_t r_flit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_flit  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_flit <= i_flit;
    end
  end

  assign o_valid = r_valid;
  assign o_flit  = r_flit;

endmodule

// File: rtl/ni_injector.sv
// Network-interface injector: segments descriptor + payload into flits for a
// router's local input port, honouring is_allocatable / is_on_off feedback.
module ni_injector
  import noc_params::*;
#(
  parameter int MAX_PKT_FLITS = 8,
  parameter int LEN_W         = $clog2(MAX_PKT_FLITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid_i,
  output logic                        pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i,
  input  logic [LEN_W-1:0]            pkt_len_i,
  input  logic                        pl_valid_i,
  output logic                        pl_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]   pl_data_i,
  output flit_t                       data_o,
  output logic                        is_valid_o,
  input  logic                        is_on_off_i,
  input  logic                        is_allocatable_i,
  output logic                        error_o
);

  typedef enum logic [1:0] {IDLE, WAIT_VC, SEND} inj_state_t;

  inj_state_t                  r_state;
  logic [LEN_W-1:0]            r_remain;
  logic [VC_SIZE-1:0]          r_vc_rr;
  logic [DEST_ADDR_SIZE_X-1:0] r_x;
  logic [DEST_ADDR_SIZE_Y-1:0] r_y;
  logic                        r_error;

  logic               w_len_ok;
  logic               w_emit;
  logic               w_last;
  logic [VC_SIZE-1:0] w_vc_next;
  flit_t              w_flit;

  assign w_len_ok  = (pkt_len_i != '0) && (pkt_len_i <= LEN_W'(MAX_PKT_FLITS));
  assign w_last    = w_emit && (r_remain == LEN_W'(1));
  assign w_vc_next = (r_vc_rr == VC_SIZE'(VC_NUM - 1)) ? '0 : r_vc_rr + 1'b1;

  assign pkt_ready_o = (r_state == IDLE);
  assign pl_ready_o  = (r_state == SEND) && is_on_off_i;

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_emit       = 1'b0;
    w_flit       = '0;
    w_flit.vc_id = r_vc_rr;
    case (r_state)
      WAIT_VC: begin
        if (is_allocatable_i && is_on_off_i) begin
          w_emit            = 1'b1;
          w_flit.flit_label = (r_remain == LEN_W'(1)) ? HEADTAIL : HEAD;
          w_flit.data       = pack_head(r_x, r_y);
        end
      end
      SEND: begin
        if (is_on_off_i && pl_valid_i) begin
          w_emit            = 1'b1;
          w_flit.flit_label = (r_remain == LEN_W'(1)) ? TAIL : BODY;
          w_flit.data       = pl_data_i;
        end
      end
      default: ;
    endcase
  end

  // vc_rr is stable for the whole packet, so it doubles as the latched vc_id.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_remain <= '0;
      r_vc_rr  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pkt_valid_i) begin
            if (w_len_ok) begin
              r_x      <= pkt_x_dest_i;
              r_y      <= pkt_y_dest_i;
              r_remain <= pkt_len_i;
              r_state  <= WAIT_VC;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        WAIT_VC, SEND: begin
          if (w_emit) begin
            r_remain <= r_remain - 1'b1;
            if (w_last) begin
              r_vc_rr <= w_vc_next;
              r_state <= IDLE;
            end else begin
              r_state <= SEND;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign error_o = r_error;

  ni_flit_reg u_flit_reg (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_emit),
    .i_flit  (w_flit),
    .o_valid (is_valid_o),
    .o_flit  (data_o)
  );

endmodule

// File: tb/tb_ni_injector.sv
// Directed self-checking bench for ni_injector with hand-computed flits.
module tb_ni_injector;
  import noc_params::*;

  localparam int MAXF = 8;
  localparam int LW   = $clog2(MAXF + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [3:0]  pkt_x_dest_i;
  logic [3:0]  pkt_y_dest_i;
  logic [LW-1:0] pkt_len_i;
  logic        pl_valid_i;
  logic        pl_ready_o;
  logic [15:0] pl_data_i;
  flit_t       data_o;
  logic        is_valid_o;
  logic        is_on_off_i;
  logic        is_allocatable_i;
  logic        error_o;

  ni_injector #(.MAX_PKT_FLITS(MAXF)) dut (
    .clk              (clk),
    .rst              (rst),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_o      (pkt_ready_o),
    .pkt_x_dest_i     (pkt_x_dest_i),
    .pkt_y_dest_i     (pkt_y_dest_i),
    .pkt_len_i        (pkt_len_i),
    .pl_valid_i       (pl_valid_i),
    .pl_ready_o       (pl_ready_o),
    .pl_data_i        (pl_data_i),
    .data_o           (data_o),
    .is_valid_o       (is_valid_o),
    .is_on_off_i      (is_on_off_i),
    .is_allocatable_i (is_allocatable_i),
    .error_o          (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_pulses = 0;

  typedef struct {
    flit_t f;
    int    c;
  } mon_t;

  mon_t        mon_q[$];
  flit_t       exp_q[$];
  logic [15:0] pl_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (is_valid_o) mon_q.push_back('{data_o, cyc});
    if (error_o) err_pulses++;
  end

  // Payload source: a word is retired after any edge where valid & ready held.
  initial begin
    bit fire;
    pl_valid_i = 1'b0;
    pl_data_i  = '0;
    forever begin
      @(negedge clk);
      fire = pl_valid_i && pl_ready_o;
      @(posedge clk);
      #1;
      if (fire && pl_q.size() > 0) void'(pl_q.pop_front());
      if (pl_q.size() > 0) begin
        pl_valid_i = 1'b1;
        pl_data_i  = pl_q[0];
      end else begin
        pl_valid_i = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input logic [VC_SIZE-1:0] v,
                               input logic [15:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = v;
    f.data       = d;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [3:0] x, input logic [3:0] y, input logic [LW-1:0] len);
    int n = 0;
    pkt_x_dest_i = x;
    pkt_y_dest_i = y;
    pkt_len_i    = len;
    pkt_valid_i  = 1'b1;
    while (!pkt_ready_o && n < 20) begin
      step();
      n++;
    end
    if (n == 20) check("desc_timeout", 32'd0, 32'd1);
    step();
    pkt_valid_i = 1'b0;
  endtask

  task automatic check_flits(input string tag);
    check({tag, "_count"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < mon_q.size()) check($sformatf("%s_flit%0d", tag, i), mon_q[i].f, exp_q[i]);
  endtask

  initial begin
    rst              = 1'b1;
    pkt_valid_i      = 1'b0;
    pkt_x_dest_i     = '0;
    pkt_y_dest_i     = '0;
    pkt_len_i        = '0;
    is_on_off_i      = 1'b1;
    is_allocatable_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_valid",     is_valid_o,  1'b0);
    check("rst_data",      data_o,      32'd0);
    check("rst_error",     error_o,     1'b0);
    check("rst_pkt_ready", pkt_ready_o, 1'b1);
    check("rst_pl_ready",  pl_ready_o,  1'b0);
    step();
    rst = 1'b0;
    step();

    // Single-flit packet: HEADTAIL on vc 0 two cycles after handshake.
    mon_q.delete();
    send_desc(4'd2, 4'd1, 1);
    @(negedge clk);
    check("t1_lat1", is_valid_o, 1'b0);
    @(negedge clk);
    check("t1_valid", is_valid_o, 1'b1);
    check("t1_flit",  data_o, mk(HEADTAIL, 1'b0, 16'h2100));
    @(negedge clk);
    check("t1_pulse", is_valid_o, 1'b0);
    check("t1_hold",  data_o, mk(HEADTAIL, 1'b0, 16'h2100));
    step();
    check("t1_count", mon_q.size(), 1);

    // Four-flit packet back to back on vc 1.
    mon_q.delete();
    pl_q = {16'h000A, 16'h000B, 16'h000C};
    send_desc(4'd3, 4'd5, 4);
    repeat (8) step();
    exp_q = {mk(HEAD, 1'b1, 16'h3500), mk(BODY, 1'b1, 16'h000A),
             mk(BODY, 1'b1, 16'h000B), mk(TAIL, 1'b1, 16'h000C)};
    check_flits("t2");
    if (mon_q.size() == 4) check("t2_b2b", mon_q[3].c - mon_q[0].c, 3);

    // On/off stall after the first BODY; vc wraps back to 0.
    mon_q.delete();
    pl_q = {16'h000A, 16'h000B, 16'h000C};
    send_desc(4'd4, 4'd2, 4);
    step();
    step();
    is_on_off_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t3_pl_ready", pl_ready_o, 1'b0);
      step();
    end
    is_on_off_i = 1'b1;
    repeat (6) step();
    exp_q = {mk(HEAD, 1'b0, 16'h4200), mk(BODY, 1'b0, 16'h000A),
             mk(BODY, 1'b0, 16'h000B), mk(TAIL, 1'b0, 16'h000C)};
    check_flits("t3");
    if (mon_q.size() == 4) check("t3_gap", mon_q[2].c - mon_q[1].c, 4);

    // VC wait: no head while is_allocatable is low for 5 cycles.
    mon_q.delete();
    pl_q = {16'h000D};
    is_allocatable_i = 1'b0;
    send_desc(4'd1, 4'd7, 2);
    repeat (5) begin
      @(negedge clk);
      check("t4_hold", is_valid_o, 1'b0);
      step();
    end
    is_allocatable_i = 1'b1;
    @(negedge clk);
    check("t4_not_yet", is_valid_o, 1'b0);
    @(negedge clk);
    check("t4_head_valid", is_valid_o, 1'b1);
    check("t4_head", data_o, mk(HEAD, 1'b1, 16'h1700));
    repeat (3) step();
    exp_q = {mk(HEAD, 1'b1, 16'h1700), mk(TAIL, 1'b1, 16'h000D)};
    check_flits("t4");

    // Third packet after reset-era wrap lands on vc 0 again.
    mon_q.delete();
    send_desc(4'd5, 4'd5, 1);
    repeat (3) step();
    exp_q = {mk(HEADTAIL, 1'b0, 16'h5500)};
    check_flits("t5");

    // Illegal lengths: error pulse each, no flits, still ready.
    mon_q.delete();
    err_pulses = 0;
    send_desc(4'd6, 4'd6, 0);
    @(negedge clk);
    check("t6_err0", error_o, 1'b1);
    check("t6_ready0", pkt_ready_o, 1'b1);
    @(negedge clk);
    check("t6_err0_end", error_o, 1'b0);
    send_desc(4'd6, 4'd6, LW'(MAXF + 1));
    @(negedge clk);
    check("t6_err9", error_o, 1'b1);
    repeat (4) step();
    check("t6_pulses", err_pulses, 2);
    check("t6_no_flits", mon_q.size(), 0);
    check("t6_ready", pkt_ready_o, 1'b1);

    // Reset after the HEAD abandons the packet; next packet restarts on vc 0.
    mon_q.delete();
    pl_q = {16'h000A, 16'h000B, 16'h000C};
    send_desc(4'd3, 4'd3, 4);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t7_head", data_o, mk(HEAD, 1'b1, 16'h3300));
    step();
    rst = 1'b0;
    @(negedge clk);
    pl_q.delete();
    check("t7_valid", is_valid_o, 1'b0);
    check("t7_pkt_ready", pkt_ready_o, 1'b1);
    check("t7_pl_ready", pl_ready_o, 1'b0);
    repeat (2) step();
    mon_q.delete();
    send_desc(4'd1, 4'd1, 1);
    repeat (3) step();
    exp_q = {mk(HEADTAIL, 1'b0, 16'h1100)};
    check_flits("t7");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
